// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt arbiter and its winner picker.
package irq_pkg;

  localparam int unsigned NumSrcDefault    = 4;
  localparam logic [11:0] IsrBaseDefault   = 12'h400;
  localparam logic [11:0] VecStrideDefault = 12'h010;

  // Width of active_id; covers up to 8 sources.
  localparam int unsigned IdW = 3;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StService,
    StReturn
  } irq_state_e;

endpackage

// File: rtl/irq_priority_pick.sv
// Combinational winner selection over the eligible vector.
// IRQ_ROUND_ROBIN_EN selects rotating search from start_i; otherwise lowest index wins.
module irq_priority_pick
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = NumSrcDefault
) (
  input  logic [NUM_SRC-1:0] eligible_i,
  input  logic [IdW-1:0]     start_i,
  output logic               valid_o,
  output logic [IdW-1:0]     idx_o
);

  logic           found;
  logic [IdW-1:0] idx;

`ifdef IRQ_ROUND_ROBIN_EN
  always_comb begin
    logic [31:0] pos;
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      pos = (32'(start_i) + k) % NUM_SRC;
      // Constant inner index keeps the select width-exact for any NUM_SRC.
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (!found && eligible_i[i] && (i == pos)) begin
          found = 1'b1;
          idx   = IdW'(i);
        end
      end
    end
  end
`else
  logic unused_start;
  assign unused_start = ^start_i;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!found && eligible_i[i]) begin
        found = 1'b1;
        idx   = IdW'(i);
      end
    end
  end
`endif

  assign valid_o = found;
  assign idx_o   = idx;

endmodule

// File: rtl/interrupt_arbiter.sv
// Edge-triggered interrupt arbiter: latches pending requests, grants one at a time and
// tracks the controller handshake. Define IRQ_ROUND_ROBIN_EN for round-robin arbitration.
module interrupt_arbiter
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC    = NumSrcDefault,
  parameter logic [11:0] ISR_BASE   = IsrBaseDefault,
  parameter logic [11:0] VEC_STRIDE = VecStrideDefault
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic               irq_mask_we,
  input  logic [NUM_SRC-1:0] irq_mask_wdata,
  input  logic               sel_ISR,
  input  logic               ret_ISR,
  output logic               interrupt_signal,
  output logic [11:0]        isr_vector,
  output logic [IdW-1:0]     active_id,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic [NUM_SRC-1:0] irq_mask
);

  localparam logic [NUM_SRC-1:0] OneHot0 = {{(NUM_SRC-1){1'b0}}, 1'b1};

  irq_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] req_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] edge_det, eligible, grant_clr;
  logic [IdW-1:0]     id_q, id_d;
  logic [11:0]        vec_q, vec_d;
  logic [IdW-1:0]     start_ptr, pick_idx;
  logic               pick_valid, grant;

  assign edge_det = irq_req & ~req_q;
  assign eligible = pend_q & ~mask_q;

  irq_priority_pick #(
    .NUM_SRC(NUM_SRC)
  ) u_pick (
    .eligible_i(eligible),
    .start_i   (start_ptr),
    .valid_o   (pick_valid),
    .idx_o     (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    vec_d   = vec_q;
    grant   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant   = 1'b1;
          state_d = StReq;
          id_d    = pick_idx;
          vec_d   = ISR_BASE + 12'(pick_idx) * VEC_STRIDE;
        end
      end
      StReq:     if (sel_ISR)  state_d = StService;
      StService: if (ret_ISR)  state_d = StReturn;
      StReturn:  if (!ret_ISR) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_clr = grant ? (OneHot0 << pick_idx) : '0;
    // A fresh edge on the granted source outranks the grant clear.
    pend_d    = (pend_q & ~grant_clr) | edge_det;
    mask_d    = irq_mask_we ? irq_mask_wdata : mask_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      req_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '1;
      id_q    <= '0;
      vec_q   <= ISR_BASE;
    end else begin
      state_q <= state_d;
      req_q   <= irq_req;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
    end
  end

`ifdef IRQ_ROUND_ROBIN_EN
  logic [IdW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = (pick_idx == IdW'(NUM_SRC - 1)) ? '0 : pick_idx + IdW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign start_ptr = ptr_q;
`else
  assign start_ptr = '0;
`endif

  assign interrupt_signal = (state_q != StReq);
  assign isr_vector       = vec_q;
  assign active_id        = id_q;
  assign irq_pending      = pend_q;
  assign irq_mask         = mask_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Self-checking bench for interrupt_arbiter: directed vector table, hand sequences and
// randomized traffic against a behavioural model.
module tb_interrupt_arbiter;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         nrst;
  logic [N-1:0] irq_req;
  logic         irq_mask_we;
  logic [N-1:0] irq_mask_wdata;
  logic         sel_ISR;
  logic         ret_ISR;
  logic         interrupt_signal;
  logic [11:0]  isr_vector;
  logic [2:0]   active_id;
  logic [N-1:0] irq_pending;
  logic [N-1:0] irq_mask;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  interrupt_arbiter dut (
    .clk             (clk),
    .nrst            (nrst),
    .irq_req         (irq_req),
    .irq_mask_we     (irq_mask_we),
    .irq_mask_wdata  (irq_mask_wdata),
    .sel_ISR         (sel_ISR),
    .ret_ISR         (ret_ISR),
    .interrupt_signal(interrupt_signal),
    .isr_vector      (isr_vector),
    .active_id       (active_id),
    .irq_pending     (irq_pending),
    .irq_mask        (irq_mask)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 requesting, 2 in service, 3 returning.
  bit m_prev [N];
  bit m_pend [N];
  bit m_mask [N];
  int m_phase, m_id, m_vec, m_ptr;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 0;
      m_pend[i] = 0;
      m_mask[i] = 1;
    end
    m_phase = 0;
    m_id    = 0;
    m_vec   = 'h400;
    m_ptr   = 0;
  endtask

  task automatic model_step();
    bit nxt [N];
    int w;
    nxt = m_pend;
    w   = -1;
    case (m_phase)
      0: begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (w < 0 && m_pend[i] && !m_mask[i]) w = i;
        end
        if (w >= 0) begin
          m_phase = 1;
          m_id    = w;
          m_vec   = ('h400 + w * 'h10) % 4096;
          nxt[w]  = 0;
`ifdef IRQ_ROUND_ROBIN_EN
          m_ptr   = (w + 1) % N;
`endif
        end
      end
      1: if (sel_ISR) m_phase = 2;
      2: if (ret_ISR) m_phase = 3;
      default: if (!ret_ISR) m_phase = 0;
    endcase
    for (int i = 0; i < N; i++) begin
      if (irq_req[i] && !m_prev[i]) nxt[i] = 1;
      m_prev[i] = irq_req[i];
      if (irq_mask_we) m_mask[i] = irq_mask_wdata[i];
    end
    m_pend = nxt;
  endtask

  function automatic logic [N-1:0] pack(input bit a [N]);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic compare_model(input string tag);
    check({tag, ".int"},  32'(interrupt_signal), (m_phase == 1) ? 0 : 1);
    check({tag, ".id"},   32'(active_id),        32'(m_id));
    check({tag, ".vec"},  32'(isr_vector),       32'(m_vec));
    check({tag, ".pend"}, 32'(irq_pending),      32'(pack(m_pend)));
    check({tag, ".mask"}, 32'(irq_mask),         32'(pack(m_mask)));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] req, input logic we, input logic [N-1:0] wd,
                       input logic sel, input logic ret);
    irq_req        = req;
    irq_mask_we    = we;
    irq_mask_wdata = wd;
    sel_ISR        = sel;
    ret_ISR        = ret;
  endtask

  task automatic do_reset();
    #2;
    nrst = 1'b0;
    model_reset();
    @(posedge clk);
    #3;
    nrst = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         we;
    logic [N-1:0] wd;
    logic         sel;
    logic         ret;
    logic         e_int;
    logic [2:0]   e_id;
    logic [11:0]  e_vec;
    logic [N-1:0] e_pend;
    logic [N-1:0] e_mask;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [N-1:0] req, input logic we, input logic [N-1:0] wd,
                              input logic sel, input logic ret, input logic e_int,
                              input logic [2:0] e_id, input logic [11:0] e_vec,
                              input logic [N-1:0] e_pend, input logic [N-1:0] e_mask);
    vec_t v;
    v.req = req; v.we = we; v.wd = wd; v.sel = sel; v.ret = ret;
    v.e_int = e_int; v.e_id = e_id; v.e_vec = e_vec; v.e_pend = e_pend; v.e_mask = e_mask;
    return v;
  endfunction

  initial begin
    nrst = 1'b0;
    drive('0, 1'b0, '0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.int",  32'(interrupt_signal), 1);
    check("reset.id",   32'(active_id),        0);
    check("reset.vec",  32'(isr_vector),       'h400);
    check("reset.pend", 32'(irq_pending),      0);
    check("reset.mask", 32'(irq_mask),         'hF);
    @(negedge clk);
    nrst = 1'b1;

`ifndef IRQ_ROUND_ROBIN_EN
    // req we wd sel ret | int id vec pend mask -- outputs after the clock edge.
    tbl.push_back(mk(4'h0, 1, 4'h0, 0, 0, 1, 0, 12'h400, 4'h0, 4'h0));
    tbl.push_back(mk(4'h4, 0, 4'h0, 0, 0, 1, 0, 12'h400, 4'h4, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 2, 12'h420, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 1, 0, 1, 2, 12'h420, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 1, 2, 12'h420, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 1, 1, 2, 12'h420, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 1, 2, 12'h420, 4'h0, 4'h0));
    tbl.push_back(mk(4'hA, 0, 4'h0, 0, 0, 1, 2, 12'h420, 4'hA, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 1, 12'h410, 4'h8, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 1, 0, 1, 1, 12'h410, 4'h8, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 1, 1, 1, 12'h410, 4'h8, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 1, 1, 12'h410, 4'h8, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 3, 12'h430, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 1, 0, 1, 3, 12'h430, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 1, 1, 3, 12'h430, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 1, 3, 12'h430, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 1, 4'h1, 0, 0, 1, 3, 12'h430, 4'h0, 4'h1));
    tbl.push_back(mk(4'h1, 0, 4'h0, 0, 0, 1, 3, 12'h430, 4'h1, 4'h1));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 1, 3, 12'h430, 4'h1, 4'h1));
    tbl.push_back(mk(4'h0, 1, 4'h0, 0, 0, 1, 3, 12'h430, 4'h1, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0, 12'h400, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 1, 0, 1, 0, 12'h400, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 1, 1, 0, 12'h400, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 1, 0, 12'h400, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 1, 4'h1, 0, 0, 1, 0, 12'h400, 4'h0, 4'h1));
    tbl.push_back(mk(4'h1, 0, 4'h0, 0, 0, 1, 0, 12'h400, 4'h1, 4'h1));
    tbl.push_back(mk(4'h0, 1, 4'h0, 0, 0, 1, 0, 12'h400, 4'h1, 4'h0));
    tbl.push_back(mk(4'h1, 0, 4'h0, 0, 0, 0, 0, 12'h400, 4'h1, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 1, 0, 1, 0, 12'h400, 4'h1, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 1, 1, 0, 12'h400, 4'h1, 4'h0));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 1, 0, 12'h400, 4'h1, 4'h0));
    tbl.push_back(mk(4'h0, 1, 4'hF, 0, 0, 0, 0, 12'h400, 4'h0, 4'hF));
    tbl.push_back(mk(4'h0, 0, 4'h0, 1, 0, 1, 0, 12'h400, 4'h0, 4'hF));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 1, 1, 0, 12'h400, 4'h0, 4'hF));
    tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 1, 0, 12'h400, 4'h0, 4'hF));

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].req, tbl[r].we, tbl[r].wd, tbl[r].sel, tbl[r].ret);
      tick();
      check($sformatf("row%0d.int", r),  32'(interrupt_signal), 32'(tbl[r].e_int));
      check($sformatf("row%0d.id", r),   32'(active_id),        32'(tbl[r].e_id));
      check($sformatf("row%0d.vec", r),  32'(isr_vector),       32'(tbl[r].e_vec));
      check($sformatf("row%0d.pend", r), 32'(irq_pending),      32'(tbl[r].e_pend));
      check($sformatf("row%0d.mask", r), 32'(irq_mask),         32'(tbl[r].e_mask));
    end
`endif

    // Reset while in service with another source pending.
    do_reset();
    drive('0, 1'b1, '0, 1'b0, 1'b0);   tick();
    drive(4'h4, 1'b0, '0, 1'b0, 1'b0); tick();
    drive('0, 1'b0, '0, 1'b0, 1'b0);   tick();
    check("midrst.granted", 32'(interrupt_signal), 0);
    drive('0, 1'b0, '0, 1'b1, 1'b0);   tick();
    drive(4'h1, 1'b0, '0, 1'b0, 1'b0); tick();
    check("midrst.pend_before", 32'(irq_pending), 1);
    #2;
    nrst = 1'b0;
    model_reset();
    #1;
    check("midrst.int",  32'(interrupt_signal), 1);
    check("midrst.pend", 32'(irq_pending),      0);
    check("midrst.mask", 32'(irq_mask),         'hF);
    check("midrst.id",   32'(active_id),        0);
    check("midrst.vec",  32'(isr_vector),       'h400);
    drive('0, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    nrst = 1'b1;
    drive('0, 1'b1, '0, 1'b0, 1'b0); tick();
    tick();
    check("midrst.after_int",  32'(interrupt_signal), 1);
    check("midrst.after_pend", 32'(irq_pending),      0);

`ifdef IRQ_ROUND_ROBIN_EN
    do_reset();
    drive('0, 1'b1, '0, 1'b0, 1'b0); tick();
    for (int r = 0; r < 4; r++) begin
      int budget;
      drive(4'h3, 1'b0, '0, 1'b0, 1'b0); tick(); compare_model("rr.pulse");
      drive(4'h0, 1'b0, '0, 1'b0, 1'b0);
      budget = 20;
      while (interrupt_signal && budget > 0) begin
        tick();
        budget--;
      end
      if (budget == 0) check("rr.wait_grant", 32'(interrupt_signal), 0);
      check($sformatf("rr.grant%0d", r), 32'(active_id), 32'(r % 2));
      drive('0, 1'b0, '0, 1'b1, 1'b0); tick(); compare_model("rr.sel");
      drive('0, 1'b0, '0, 1'b0, 1'b1); tick(); compare_model("rr.ret");
      drive('0, 1'b0, '0, 1'b0, 1'b0); tick(); compare_model("rr.idle");
    end
`endif

    // Randomized traffic against the model, with occasional asynchronous resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] req, wd;
      req = '0;
      for (int i = 0; i < N; i++) req[i] = ($urandom_range(0, 3) == 0);
      wd = N'($urandom) & N'($urandom);
      drive(req, ($urandom_range(0, 7) == 0), wd, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 399) == 0) begin
        #2;
        nrst = 1'b0;
        model_reset();
        #1;
        compare_model("rnd.rst");
        @(posedge clk);
        #3;
        nrst = 1'b1;
      end else begin
        tick();
        compare_model("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
